// File: rtl/fd_packet_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fd_packet_feeder_pkg
// Description : Shared constants for the fetch-to-decode packet feeder. This
//               covers the side-band field widths, the bit positions inside
//               push_ctrl/ctrl_out, and the feeder FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fd_packet_feeder_pkg;

  localparam int FD_CTRL_W   = 6;
  localparam int IE_TYPE_W   = 4;
  localparam int BP_ALIAS_W  = 8;
  localparam int BR_TARGET_W = 32;

  // Bit positions inside push_ctrl / ctrl_out
  localparam int CTRL_IDTR_ORIG     = 5;  // instr_is_IDTR_orig
  localparam int CTRL_IDTR_POP_EFL  = 4;  // IDTR_is_POP_EFLAGS
  localparam int CTRL_P_OP_1_2      = 3;
  localparam int CTRL_P_OP_21_22    = 2;
  localparam int CTRL_P_OP_22_23    = 1;
  localparam int CTRL_INV_OP1_WB    = 0;  // invalidate_op1_wb

  // Feeder FSM encoding
  localparam logic [0:0] RUN        = 1'b0;
  localparam logic [0:0] FAULT_HOLD = 1'b1;

  // Width of one stored entry: packet + alias + target + tnt + ie + ie_type + ctrl
  function automatic int entry_w(input int pkt_w);
    return pkt_w + BP_ALIAS_W + BR_TARGET_W + 1 + 1 + IE_TYPE_W + FD_CTRL_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fd_packet_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : fd_packet_feeder_if
// Description : Fetch-push / latch-load bus of the fetch-to-decode feeder.
//               master : fetch + latch control side (drives push_*, latch_ld,
//                        flush; observes push_ready and head outputs)
//               slave  : the feeder itself
// Revision    : 1.0 - initial release
// ============================================================================
interface fd_packet_feeder_if #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 128
);
  import fd_packet_feeder_pkg::*;

  // Push side
  logic                   push_valid;
  logic                   push_ready;
  logic [PKT_W-1:0]       push_packet;
  logic [BP_ALIAS_W-1:0]  push_bp_alias;
  logic [BR_TARGET_W-1:0] push_br_target;
  logic                   push_br_tnt;
  logic                   push_ie;
  logic [IE_TYPE_W-1:0]   push_ie_type;
  logic [FD_CTRL_W-1:0]   push_ctrl;

  // Latch control
  logic                   latch_ld;
  logic                   flush;

  // Head / latch input side
  logic                   valid_out;
  logic [PKT_W-1:0]       packet_out;
  logic [BP_ALIAS_W-1:0]  bp_alias_out;
  logic [BR_TARGET_W-1:0] br_target_out;
  logic                   br_tnt_out;
  logic                   ie_out;
  logic [IE_TYPE_W-1:0]   ie_type_out;
  logic [FD_CTRL_W-1:0]   ctrl_out;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output push_valid, push_packet, push_bp_alias, push_br_target, push_br_tnt,
           push_ie, push_ie_type, push_ctrl, latch_ld, flush,
    input  push_ready, valid_out, packet_out, bp_alias_out, br_target_out,
           br_tnt_out, ie_out, ie_type_out, ctrl_out, count
  );

  modport slave (
    input  push_valid, push_packet, push_bp_alias, push_br_target, push_br_tnt,
           push_ie, push_ie_type, push_ctrl, latch_ld, flush,
    output push_ready, valid_out, packet_out, bp_alias_out, br_target_out,
           br_tnt_out, ie_out, ie_type_out, ctrl_out, count
  );

endinterface
`default_nettype wire

// File: rtl/fd_feeder_ram.sv
`default_nettype none
// ============================================================================
// Module      : fd_feeder_ram
// Description : DEPTH x W register array, one synchronous write port and one
//               combinational read port. Contents are not reset; the owner
//               qualifies reads with its own occupancy.
// Ports       : clk      - write clock
//               i_we     - write enable
//               i_waddr  - write index
//               i_wdata  - write data
//               i_raddr  - read index
//               o_rdata  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module fd_feeder_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 180
) (
  input  wire logic                     clk,
  input  wire logic                     i_we,
  input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
  input  wire logic [W-1:0]             i_wdata,
  input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic      [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fd_packet_feeder.sv
`default_nettype none
// ============================================================================
// Module      : fd_packet_feeder
// Description : Producer side of the fetch-to-decode latch. This is a circular
//               buffer of fetch entries. It presents the head entry each cycle,
//               pops it on latch_ld, and discards all entries on flush. When an
//               exception entry is accepted, fetch is frozen (FAULT_HOLD) until
//               the next flush.
// Ports       : clk  - pipeline clock
//               clr  - asynchronous active-low reset
//               bus  - fd_packet_feeder_if.slave (push, latch control, head)
// Option      : FD_FEEDER_BYPASS_EN - when defined, a push into an empty
//               feeder that is loaded in the same cycle bypasses storage and
//               drives the head outputs combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module fd_packet_feeder #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 128
) (
  input  wire logic          clk,
  input  wire logic          clr,
  fd_packet_feeder_if.slave  bus
);
  import fd_packet_feeder_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(PKT_W);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [0:0]    r_state;

  logic          w_empty;
  logic          w_full;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_wr;
  logic          w_bypass;
  logic [EW-1:0] w_wr_data;
  logic [EW-1:0] w_rd_data;
  logic [EW-1:0] w_out_data;
  logic          w_out_valid;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // A full feeder still accepts when the head leaves in the same cycle.
  assign w_ready = (r_state == RUN) && (!w_full || bus.latch_ld);
  assign w_push  = bus.push_valid && w_ready;
  assign w_pop   = bus.latch_ld && !w_empty;

`ifdef FD_FEEDER_BYPASS_EN
  assign w_bypass = w_empty && w_push && bus.latch_ld && !bus.flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A push in a flush cycle is dropped; a bypassed push never lands in storage.
  assign w_wr = w_push && !bus.flush && !w_bypass;

  assign w_wr_data = {bus.push_packet, bus.push_bp_alias, bus.push_br_target,
                      bus.push_br_tnt, bus.push_ie, bus.push_ie_type, bus.push_ctrl};

  fd_feeder_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_tail),
    .i_wdata (w_wr_data),
    .i_raddr (r_head),
    .o_rdata (w_rd_data)
  );

  // Head outputs. Payload is forced to zero when empty so the latch captures a
  // clean bubble and stale storage is never visible.
  always_comb begin
    w_out_valid = !w_empty;
    w_out_data  = w_empty ? '0 : w_rd_data;
    if (w_bypass) begin
      w_out_valid = 1'b1;
      w_out_data  = w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= RUN;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= RUN;
    end else begin
      if (w_wr) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Accepted exception entry (stored or bypassed) freezes fetch until flush.
      if (w_push && bus.push_ie) begin
        r_state <= FAULT_HOLD;
      end
    end
  end

  assign bus.push_ready = w_ready;
  assign bus.valid_out  = w_out_valid;
  assign bus.count      = r_count;
  assign {bus.packet_out, bus.bp_alias_out, bus.br_target_out, bus.br_tnt_out,
          bus.ie_out, bus.ie_type_out, bus.ctrl_out} = w_out_data;

endmodule
`default_nettype wire

// File: tb/tb_fd_packet_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fd_packet_feeder
// Description : Self-checking bench for fd_packet_feeder. It keeps a queue model
//               of stored entries and a fault flag, and checks push_ready,
//               valid_out, the head payload and count in every stepped cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fd_packet_feeder;
  import fd_packet_feeder_pkg::*;

  localparam int DEPTH = 4;
  localparam int PKT_W = 128;
  localparam int XW    = 180;

  typedef struct packed {
    logic [PKT_W-1:0]       pkt;
    logic [BP_ALIAS_W-1:0]  al;
    logic [BR_TARGET_W-1:0] tgt;
    logic                   tnt;
    logic                   ie;
    logic [IE_TYPE_W-1:0]   iet;
    logic [FD_CTRL_W-1:0]   ctrl;
  } ent_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  fd_packet_feeder_if #(.DEPTH(DEPTH), .PKT_W(PKT_W)) bus ();

  fd_packet_feeder #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  int   n_vec = 0;
  int   n_err = 0;
  ent_t q[$];
  logic m_fault = 1'b0;

  task automatic chk(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input int k, input logic ie, input logic [3:0] iet);
    ent_t e;
    e.pkt  = {16{8'(k)}};
    e.al   = 8'(k + 8'h40);
    e.tgt  = 32'h1000_0000 + 32'(k * 4);
    e.tnt  = k[0];
    e.ie   = ie;
    e.iet  = iet;
    e.ctrl = 6'(k ^ 21);
    return e;
  endfunction

  function automatic ent_t head_obs();
    return {bus.packet_out, bus.bp_alias_out, bus.br_target_out, bus.br_tnt_out,
            bus.ie_out, bus.ie_type_out, bus.ctrl_out};
  endfunction

  // One cycle: drive inputs, check outputs against the model, update the model.
  task automatic step(input string tag, input logic pv, input ent_t e,
                      input logic ld, input logic fl);
    logic exp_rdy, acc, byp, exp_v;
    ent_t exp_out;
    @(negedge clk);
    bus.push_valid = pv;
    {bus.push_packet, bus.push_bp_alias, bus.push_br_target, bus.push_br_tnt,
     bus.push_ie, bus.push_ie_type, bus.push_ctrl} = e;
    bus.latch_ld = ld;
    bus.flush    = fl;
    #1;
    exp_rdy = !m_fault && ((q.size() < DEPTH) || ld);
    acc     = pv && exp_rdy;
    byp     = 1'b0;
`ifdef FD_FEEDER_BYPASS_EN
    byp     = (q.size() == 0) && acc && ld && !fl;
`endif
    exp_v   = (q.size() > 0) || byp;
    exp_out = (q.size() > 0) ? q[0] : (byp ? e : ent_t'('0));
    chk({tag, ":ready"},   XW'(bus.push_ready), XW'(exp_rdy));
    chk({tag, ":valid"},   XW'(bus.valid_out),  XW'(exp_v));
    chk({tag, ":payload"}, XW'(head_obs()),     XW'(exp_out));
    chk({tag, ":count"},   XW'(bus.count),      XW'(q.size()));
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_fault = 1'b0;
    end else begin
      if (ld && q.size() > 0) void'(q.pop_front());
      if (acc && !byp) q.push_back(e);
      if (acc && e.ie) m_fault = 1'b1;
    end
  endtask

  task automatic idle(input string tag, input logic ld);
    step(tag, 1'b0, ent_t'('0), ld, 1'b0);
  endtask

  initial begin
    ent_t p0;
    ent_t pdb;
    p0     = mk(0, 1'b0, 4'h0);
    p0.pkt = 128'h000102030405060708090A0B0C0D0E0F;
    p0.al  = 8'h11;
    pdb     = mk(99, 1'b0, 4'h0);
    pdb.pkt = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

    bus.push_valid = 1'b0; bus.latch_ld = 1'b0; bus.flush = 1'b0;
    {bus.push_packet, bus.push_bp_alias, bus.push_br_target, bus.push_br_tnt,
     bus.push_ie, bus.push_ie_type, bus.push_ctrl} = '0;

    // Reset state
    #12;
    chk("rst:valid",   XW'(bus.valid_out), XW'(0));
    chk("rst:count",   XW'(bus.count),     XW'(0));
    chk("rst:payload", XW'(head_obs()),    XW'(0));
    @(negedge clk);
    clr = 1'b1;

    // Single push, 1-cycle latency, then held stable
    step("push0", 1'b1, p0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle("hold", 1'b0);

    // Fill to DEPTH, offer while full without load, then push+pop across wrap
    for (int i = 1; i < 4; i++) step("fill", 1'b1, mk(i, 1'b0, 4'h0), 1'b0, 1'b0);
    step("full_noload", 1'b1, mk(4, 1'b0, 4'h0), 1'b0, 1'b0);
    for (int i = 4; i < 10; i++) step("wrap", 1'b1, mk(i, 1'b0, 4'h0), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle("drain", 1'b1);

    // Load on empty: bubble, nothing changes
    idle("bubble", 1'b1);
    idle("bubble2", 1'b1);

    // Exception entry freezes fetch until flush
    step("ie_push", 1'b1, mk(20, 1'b1, 4'h3), 1'b0, 1'b0);
    step("frozen1", 1'b1, mk(21, 1'b0, 4'h0), 1'b0, 1'b0);
    step("frozen2", 1'b1, mk(22, 1'b0, 4'h0), 1'b0, 1'b0);
    idle("ie_drain", 1'b1);
    idle("ie_empty", 1'b1);
    step("ie_flush", 1'b0, ent_t'('0), 1'b0, 1'b1);
    idle("ie_run", 1'b0);

    // Flush beats simultaneous push and pop
    for (int i = 30; i < 33; i++) step("pre_fl", 1'b1, mk(i, 1'b0, 4'h0), 1'b0, 1'b0);
    step("fl_all", 1'b1, mk(33, 1'b0, 4'h0), 1'b1, 1'b1);
    idle("post_fl", 1'b0);

    // Push into empty while loading (bypass or 1-cycle latency)
    step("byp", 1'b1, pdb, 1'b1, 1'b0);
    idle("byp_next", 1'b0);
    idle("byp_clean", 1'b1);
    idle("byp_end", 1'b0);

    // Asynchronous reset mid-operation discards everything immediately
    step("pre_rst", 1'b1, mk(40, 1'b0, 4'h0), 1'b0, 1'b0);
    step("pre_rst2", 1'b1, mk(41, 1'b1, 4'h7), 1'b0, 1'b0);
    @(negedge clk);
    bus.push_valid = 1'b0;
    #2 clr = 1'b0;
    #1;
    chk("mid_rst:count", XW'(bus.count),     XW'(0));
    chk("mid_rst:valid", XW'(bus.valid_out), XW'(0));
    q.delete();
    m_fault = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    idle("after_rst", 1'b0);
    step("after_rst_push", 1'b1, mk(50, 1'b0, 4'h0), 1'b0, 1'b0);
    idle("after_rst_head", 1'b1);
    idle("after_rst_end", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
